// File: rtl/tcm_pkg.sv
// Shared types and helpers for the TCM request bridge.
package tcm_pkg;

    localparam int TCM_DATA_WIDTH = 32;
    localparam int TCM_ADDR_WIDTH = 15;

    // One response as it sits in the response FIFO.
    typedef struct packed {
        logic [TCM_DATA_WIDTH-1:0] rdata;
        logic                      we;
        logic                      err;
    } tcm_rsp_t;

    // Word accesses only: the two low byte-address bits must be zero.
    function automatic logic is_aligned(input logic [TCM_ADDR_WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/tcm_rsp_fifo.sv
// In-order response FIFO with wrap-around pointers and an occupancy count.
// Simultaneous push and pop keep the count unchanged, including when full.
module tcm_rsp_fifo
    import tcm_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  tcm_rsp_t         push_data_i,
    input  logic             pop_i,
    output tcm_rsp_t         head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    tcm_rsp_t         mem_q [DEPTH];
    logic             push_eff;
    logic             pop_eff;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign head_o   = mem_q[rd_ptr_q];
    // A pop on an empty FIFO is ignored; a push when full only lands if a pop frees the slot.
    assign pop_eff  = pop_i & ~empty_o;
    assign push_eff = push_i & (~full_o | pop_eff);

    // Pointer and count next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_eff) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_eff)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are don't-care while the slot is not occupied.
    always_ff @(posedge clk_i) begin
        if (push_eff) mem_q[wr_ptr_q] <= push_data_i;
    end

    // The upstream credit logic must never push into a full FIFO that is not draining.
    overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 !(push_i && full_o && !pop_i));

endmodule

// File: rtl/tcm_req_bridge.sv
// Bridge from a valid-ready request channel to a single-port TCM with
// one-cycle read latency, returning in-order responses through a FIFO.
module tcm_req_bridge
    import tcm_pkg::*;
#(
    parameter int DATA_WIDTH = TCM_DATA_WIDTH,
    parameter int ADDR_WIDTH = TCM_ADDR_WIDTH,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_we_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_we_o,
    output logic                    rsp_err_o,
    output logic                    tcm_en_o,
    output logic                    tcm_we_o,
    output logic [ADDR_WIDTH-1:0]   tcm_addr_o,
    output logic [DATA_WIDTH/8-1:0] tcm_be_o,
    output logic [DATA_WIDTH-1:0]   tcm_wdata_o,
    input  logic [DATA_WIDTH-1:0]   tcm_rdata_i
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic             fire;
    logic             aligned;
    logic             pop;
    logic [OCC_W-1:0] occupancy;

    logic             inflight_q, inflight_d;
    logic             infl_we_q, infl_we_d;
    logic             infl_err_q, infl_err_d;

    tcm_rsp_t         push_data;
    tcm_rsp_t         head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    assign aligned = is_aligned(TCM_ADDR_WIDTH'(req_addr_i));
    assign pop     = rsp_valid_o & rsp_ready_i;

    // Credit check and zero-latency TCM drive; a slot freed by this cycle's pop is reusable now.
    always_comb begin
        occupancy   = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
        req_ready_o = rst_ni & (occupancy < OCC_W'(RSP_DEPTH));
        fire        = req_valid_i & req_ready_o;
        tcm_en_o    = fire & aligned;
        tcm_we_o    = 1'b0;
        tcm_addr_o  = '0;
        tcm_be_o    = '0;
        tcm_wdata_o = '0;
        if (tcm_en_o) begin
            tcm_we_o    = req_we_i;
            tcm_addr_o  = req_addr_i;
            tcm_be_o    = req_be_i;
            tcm_wdata_o = req_wdata_i;
        end
    end

    // Inflight stage next-state: remembers what was issued so its response can be built next cycle.
    always_comb begin
        inflight_d = fire;
        infl_we_d  = infl_we_q;
        infl_err_d = infl_err_q;
        if (fire) begin
            infl_we_d  = req_we_i;
            infl_err_d = ~aligned;
        end
    end

    // Inflight stage register; reset drops any access still waiting for its response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            inflight_q <= 1'b0;
            infl_we_q  <= 1'b0;
            infl_err_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            infl_we_q  <= infl_we_d;
            infl_err_q <= infl_err_d;
        end
    end

    // Build the response one cycle after issue; TCM read data is only meaningful in this cycle.
    always_comb begin
        push_data.rdata = (!infl_we_q && !infl_err_q) ? tcm_rdata_i : '0;
        push_data.we    = infl_we_q;
        push_data.err   = infl_err_q;
    end

    tcm_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (inflight_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Response channel driven from the FIFO head, zeroed when nothing is valid.
    always_comb begin
        rsp_valid_o = ~fifo_empty;
        rsp_rdata_o = '0;
        rsp_we_o    = 1'b0;
        rsp_err_o   = 1'b0;
        if (rsp_valid_o) begin
            rsp_rdata_o = head.rdata;
            rsp_we_o    = head.we;
            rsp_err_o   = head.err;
        end
    end

endmodule

// File: tb/tb_tcm_req_bridge.sv
// Directed self-checking bench for tcm_req_bridge with a behavioural TCM model.
module tb_tcm_req_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [14:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_we, rsp_err;
    logic [31:0] rsp_rdata;
    logic        tcm_en, tcm_we;
    logic [14:0] tcm_addr;
    logic [3:0]  tcm_be;
    logic [31:0] tcm_wdata;
    logic [31:0] tcm_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tcm_req_bridge dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_we_i    (req_we),
        .req_be_i    (req_be),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_we_o    (rsp_we),
        .rsp_err_o   (rsp_err),
        .tcm_en_o    (tcm_en),
        .tcm_we_o    (tcm_we),
        .tcm_addr_o  (tcm_addr),
        .tcm_be_o    (tcm_be),
        .tcm_wdata_o (tcm_wdata),
        .tcm_rdata_i (tcm_rdata)
    );

    // TCM model: 8192 words, byte-enabled writes, registered read data.
    logic [31:0] mem [0:8191];
    bit          mem_init_done = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        if (i < 8) return 32'(i);
        if (i == 8) return 32'h1122_3344;
        if (i >= 16 && i < 20) return 32'(32'hA0 + i - 16);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 8192; i++) mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
            tcm_rdata     <= 32'h0;
        end else if (tcm_en) begin
            if (tcm_we) begin
                for (int b = 0; b < 4; b++)
                    if (tcm_be[b]) mem[tcm_addr[14:2]][b*8 +: 8] <= tcm_wdata[b*8 +: 8];
            end else begin
                tcm_rdata <= mem[tcm_addr[14:2]];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic we, input logic [14:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_be    = be;
        req_wdata = wd;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        set_req(1'b1, 1'b0, 15'h0, 4'hF, 32'h0);
        step();
        step();
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (tcm_en !== 1'b0) begin errors++; $display("FAIL reset_tcm_en: got %b expected 0", tcm_en); end
        checks++; if ({rsp_valid, rsp_we, rsp_err, rsp_rdata} !== 35'h0) begin errors++;
            $display("FAIL reset_rsp: got v=%b we=%b err=%b d=%h expected all 0", rsp_valid, rsp_we, rsp_err, rsp_rdata); end
        set_req(1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        rst_n = 1'b1;
        step();
        checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++;
            $display("FAIL after_reset: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, req_ready); end
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c < 8) set_req(1'b1, 1'b0, 15'(4 * c), 4'hF, 32'h0);
            else       set_req(1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
            #1;
            if (c < 8) begin
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c=%0d: got %b expected 1", c, req_ready); end
            end
            if (c >= 2 && c < 10) begin
                checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'(c - 2)}) begin errors++;
                    $display("FAIL b2b_rsp c=%0d: got v=%b err=%b d=%h expected v=1 err=0 d=%h", c, rsp_valid, rsp_err, rsp_rdata, 32'(c - 2)); end
            end
            if (c == 10) begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got valid=%b expected 0", rsp_valid); end
            end
            step();
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        set_req(1'b1, 1'b1, 15'h0010, 4'hF, 32'hDEAD_BEEF);
        #1;
        checks++; if ({tcm_en, tcm_we, tcm_addr, tcm_be, tcm_wdata} !== {1'b1, 1'b1, 15'h0010, 4'hF, 32'hDEAD_BEEF}) begin errors++;
            $display("FAIL wr_tcm_drive: got en=%b we=%b a=%h be=%h d=%h expected en=1 we=1 a=0010 be=f d=deadbeef", tcm_en, tcm_we, tcm_addr, tcm_be, tcm_wdata); end
        step();
        set_req(1'b1, 1'b0, 15'h0010, 4'hF, 32'h0);
        #1;
        checks++; if ({tcm_en, tcm_we, tcm_addr} !== {1'b1, 1'b0, 15'h0010}) begin errors++;
            $display("FAIL rd_tcm_drive: got en=%b we=%b a=%h expected en=1 we=0 a=0010", tcm_en, tcm_we, tcm_addr); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_early: got valid=%b expected 0", rsp_valid); end
        step();
        set_req(1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        #1;
        checks++; if (tcm_en !== 1'b0) begin errors++; $display("FAIL tcm_en_pulse: got %b expected 0", tcm_en); end
        checks++; if ({rsp_valid, rsp_we, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin errors++;
            $display("FAIL wr_ack: got v=%b we=%b err=%b d=%h expected v=1 we=1 err=0 d=0", rsp_valid, rsp_we, rsp_err, rsp_rdata); end
        step();
        checks++; if ({rsp_valid, rsp_we, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF}) begin errors++;
            $display("FAIL rd_data: got v=%b we=%b err=%b d=%h expected v=1 we=0 err=0 d=deadbeef", rsp_valid, rsp_we, rsp_err, rsp_rdata); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rd_drain: got valid=%b expected 0", rsp_valid); end
        $display("test_write_read done");
    endtask

    task automatic test_byte_write();
        rsp_ready = 1'b1;
        set_req(1'b1, 1'b1, 15'h0020, 4'h2, 32'h0000_AB00);
        #1;
        checks++; if (tcm_be !== 4'h2) begin errors++; $display("FAIL byte_be: got %h expected 2", tcm_be); end
        step();
        set_req(1'b1, 1'b0, 15'h0020, 4'hF, 32'h0);
        step();
        set_req(1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        #1;
        checks++; if ({rsp_valid, rsp_we, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin errors++;
            $display("FAIL byte_ack: got v=%b we=%b d=%h expected v=1 we=1 d=0", rsp_valid, rsp_we, rsp_rdata); end
        step();
        checks++; if ({rsp_valid, rsp_we, rsp_rdata} !== {1'b1, 1'b0, 32'h1122_AB44}) begin errors++;
            $display("FAIL byte_merge: got v=%b we=%b d=%h expected v=1 we=0 d=1122ab44", rsp_valid, rsp_we, rsp_rdata); end
        step();
        $display("test_byte_write done");
    endtask

    task automatic test_backpressure();
        logic [10:0] exp_rdy = 11'b011_1100_0011;
        logic [10:0] exp_vld = 11'b011_1111_1100;
        logic [31:0] exp_head [11] = '{32'h0, 32'h0, 32'hA0, 32'hA0, 32'hA0, 32'hA0, 32'hA0,
                                       32'hA1, 32'hA2, 32'hA3, 32'h0};
        int idx = 0;
        for (int c = 0; c <= 10; c++) begin
            rsp_ready = (c >= 6);
            if (idx < 4) set_req(1'b1, 1'b0, 15'(32'h40 + 4 * idx), 4'hF, 32'h0);
            else         set_req(1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
            #1;
            if (c < 10) begin
                checks++; if (req_ready !== exp_rdy[c]) begin errors++;
                    $display("FAIL bp_ready c=%0d: got %b expected %b", c, req_ready, exp_rdy[c]); end
            end
            checks++; if ({rsp_valid, rsp_rdata} !== {exp_vld[c], exp_head[c]}) begin errors++;
                $display("FAIL bp_rsp c=%0d: got v=%b d=%h expected v=%b d=%h", c, rsp_valid, rsp_rdata, exp_vld[c], exp_head[c]); end
            if (req_valid && req_ready) idx++;
            step();
        end
        checks++; if (idx !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", idx); end
        $display("test_backpressure done");
    endtask

    task automatic test_misaligned();
        rsp_ready = 1'b1;
        set_req(1'b1, 1'b0, 15'h0004, 4'hF, 32'h0);
        #1;
        checks++; if (tcm_en !== 1'b1) begin errors++; $display("FAIL mis_first_en: got %b expected 1", tcm_en); end
        step();
        set_req(1'b1, 1'b0, 15'h0006, 4'hF, 32'h0);
        #1;
        checks++; if ({req_ready, tcm_en, tcm_addr} !== {1'b1, 1'b0, 15'h0}) begin errors++;
            $display("FAIL mis_no_access: got ready=%b en=%b a=%h expected ready=1 en=0 a=0", req_ready, tcm_en, tcm_addr); end
        step();
        set_req(1'b1, 1'b0, 15'h0008, 4'hF, 32'h0);
        #1;
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h1}) begin errors++;
            $display("FAIL mis_before: got v=%b err=%b d=%h expected v=1 err=0 d=1", rsp_valid, rsp_err, rsp_rdata); end
        step();
        set_req(1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        #1;
        checks++; if ({rsp_valid, rsp_we, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin errors++;
            $display("FAIL mis_err: got v=%b we=%b err=%b d=%h expected v=1 we=0 err=1 d=0", rsp_valid, rsp_we, rsp_err, rsp_rdata); end
        step();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h2}) begin errors++;
            $display("FAIL mis_after: got v=%b err=%b d=%h expected v=1 err=0 d=2", rsp_valid, rsp_err, rsp_rdata); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mis_drain: got valid=%b expected 0", rsp_valid); end
        $display("test_misaligned done");
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        set_req(1'b1, 1'b0, 15'h0040, 4'hF, 32'h0);
        step();
        set_req(1'b1, 1'b0, 15'h0044, 4'hF, 32'h0);
        step();
        set_req(1'b1, 1'b0, 15'h0048, 4'hF, 32'h0);
        #1;
        checks++; if ({rsp_valid, req_ready} !== 2'b10) begin errors++;
            $display("FAIL rm_full: got valid=%b ready=%b expected valid=1 ready=0", rsp_valid, req_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if ({req_ready, tcm_en} !== 2'b00) begin errors++;
            $display("FAIL rm_in_reset: got ready=%b en=%b expected 0 0", req_ready, tcm_en); end
        step();
        checks++; if ({rsp_valid, req_ready, rsp_rdata} !== {1'b0, 1'b0, 32'h0}) begin errors++;
            $display("FAIL rm_cleared: got valid=%b ready=%b d=%h expected 0 0 0", rsp_valid, req_ready, rsp_rdata); end
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        set_req(1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        step();
        set_req(1'b1, 1'b0, 15'h0020, 4'hF, 32'h0);
        #1;
        checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++;
            $display("FAIL rm_no_stale: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, req_ready); end
        step();
        set_req(1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_latency: got valid=%b expected 0", rsp_valid); end
        step();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h1122_AB44}) begin errors++;
            $display("FAIL rm_new_read: got v=%b err=%b d=%h expected v=1 err=0 d=1122ab44", rsp_valid, rsp_err, rsp_rdata); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_drain: got valid=%b expected 0", rsp_valid); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_write_read();
        test_byte_write();
        test_backpressure();
        test_misaligned();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
